// File: rtl/alu_seq.sv
// Handshaked sequential ALU: NOP..LSR plus ADC, registered Z/N/C/V flags,
// serial (1 bit/cycle) or barrel shifting, one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH      = 16,
  parameter int SHIFT_MODE = 0
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Fn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic [1:0]       DbgState
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] FN_ACC = 4'd1;
  localparam logic [3:0] FN_MEM = 4'd2;
  localparam logic [3:0] FN_ADD = 4'd3;
  localparam logic [3:0] FN_SUB = 4'd4;
  localparam logic [3:0] FN_AND = 4'd5;
  localparam logic [3:0] FN_OR  = 4'd6;
  localparam logic [3:0] FN_NOT = 4'd7;
  localparam logic [3:0] FN_LSL = 4'd8;
  localparam logic [3:0] FN_LSR = 4'd9;
  localparam logic [3:0] FN_ADC = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       fn_q, fn_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH:0]   add_sum, sub_diff, lsl_ext, lsr_ext;
  logic [WIDTH-1:0] ex_res, sh_next;
  logic             ex_c, ex_v, ex_upd, sh_c;

  // Single-cycle datapath; the extra top/bottom bit of the shift vectors
  // holds the last bit shifted out. Flags are {Z,N,C,V}.
  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, (fn_q == FN_ADC) & flags_q[1]};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    lsl_ext  = {1'b0, a_q} << cnt_q;
    lsr_ext  = {a_q, 1'b0} >> cnt_q;
    ex_res   = a_q;
    ex_c     = flags_q[1];
    ex_v     = flags_q[0];
    ex_upd   = 1'b1;
    case (fn_q)
      FN_ACC, FN_MEM: ex_res = b_q;
      FN_ADD, FN_ADC: begin
        ex_res = add_sum[WIDTH-1:0];
        ex_c   = add_sum[WIDTH];
        ex_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ex_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      FN_SUB: begin
        ex_res = sub_diff[WIDTH-1:0];
        ex_c   = ~sub_diff[WIDTH];
        ex_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ex_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      FN_AND: ex_res = a_q & b_q;
      FN_OR:  ex_res = a_q | b_q;
      FN_NOT: ex_res = ~a_q;
      FN_LSL: if (cnt_q != '0) begin
        ex_res = lsl_ext[WIDTH-1:0];
        ex_c   = lsl_ext[WIDTH];
      end
      FN_LSR: if (cnt_q != '0) begin
        ex_res = lsr_ext[WIDTH:1];
        ex_c   = lsr_ext[0];
      end
      default: ex_upd = 1'b0;
    endcase
  end

  always_comb begin
    if (fn_q == FN_LSL) begin
      sh_next = wrk_q << 1;
      sh_c    = wrk_q[WIDTH-1];
    end else begin
      sh_next = wrk_q >> 1;
      sh_c    = wrk_q[0];
    end
  end

  // Handshake: an op is taken on any edge with InValid=1 while InReady=1 (IDLE);
  // the result is held while OutValid=1 until an edge sees OutReady=1.
  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    a_d     = a_q;
    b_d     = b_q;
    wrk_d   = wrk_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          fn_d  = Fn;
          a_d   = A;
          b_d   = B;
          wrk_d = A;
          cnt_d = B[SW-1:0];
          if (SHIFT_MODE == 0 && (Fn == FN_LSL || Fn == FN_LSR) && B[SW-1:0] != '0)
            state_d = S_SHIFT;
          else
            state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = ex_res;
        if (ex_upd)
          flags_d = {ex_res == '0, ex_res[WIDTH-1], ex_c, ex_v};
        state_d = S_DONE;
      end
      S_SHIFT: begin
        wrk_d = sh_next;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          res_d   = sh_next;
          flags_d = {sh_next == '0, sh_next[WIDTH-1], sh_c, flags_q[0]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (OutReady)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      fn_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wrk_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wrk_q   <= wrk_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_DONE);
  assign Result   = res_q;
  assign Flags    = flags_q;
  assign DbgState = state_q;

endmodule
